lvds_rx_align_ctrl: RTL and testbench

Per-channel word-alignment sequencer for the multi-channel LVDS receiver.
- After a start pulse, services channels one at a time: waits for DPA lock, resets the FIFO and bitslip logic, then issues bitslip pulses until the deserialized word matches a training pattern.
- Sits in the rx_slowclk domain beside the receiver. Drives its per-channel control inputs and reports per-channel pass/fail status to link-training firmware.

---
 rtl/lvds_rx_align_ctrl_if.sv | 28 ++
 rtl/lvds_rx_align_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_lvds_rx_align_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lvds_rx_align_ctrl_if.sv
// Control/status bundle between the LVDS receiver, the alignment sequencer and firmware.
interface lvds_rx_align_ctrl_if #(
    parameter int number_of_channels     = 4,
    parameter int deserialization_factor = 8
);
    logic                                                 start;
    logic [number_of_channels*deserialization_factor-1:0] rx_out;
    logic [number_of_channels-1:0]                        rx_dpa_locked;
    logic [number_of_channels-1:0]                        rx_fifo_reset;
    logic [number_of_channels-1:0]                        rx_cda_reset;
    logic [number_of_channels-1:0]                        rx_channel_data_align;
    logic                                                 busy;
    logic                                                 done;
    logic [number_of_channels-1:0]                        align_ok;
    logic [number_of_channels-1:0]                        align_fail;

    modport master (
        output start, rx_out, rx_dpa_locked,
        input  rx_fifo_reset, rx_cda_reset, rx_channel_data_align,
        input  busy, done, align_ok, align_fail
    );

    modport slave (
        input  start, rx_out, rx_dpa_locked,
        output rx_fifo_reset, rx_cda_reset, rx_channel_data_align,
        output busy, done, align_ok, align_fail
    );
endinterface

// File: rtl/lvds_rx_align_ctrl.sv
// Per-channel word-alignment sequencer: DPA wait, FIFO/CDA reset, bitslip until the
// training pattern is seen lock_match_count times in a row.
module lvds_rx_align_ctrl #(
    parameter int                                 number_of_channels     = 4,
    parameter int                                 deserialization_factor = 8,
    parameter logic [deserialization_factor-1:0] training_pattern       = 8'h6A,
    parameter int                                 data_align_rollover    = deserialization_factor,
    parameter string                              enable_dpa_mode        = "ON",
    parameter int                                 settle_cycles          = 4,
    parameter int                                 lock_match_count       = 3,
    parameter int                                 dpa_timeout            = 1024
) (
    input logic                rx_slowclk,
    input logic                rx_reset,
    lvds_rx_align_ctrl_if.slave bus
);
    localparam int NCH    = number_of_channels;
    localparam int DF     = deserialization_factor;
    localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SW     = $clog2(data_align_rollover + 1);
    localparam bit DPA_ON = (enable_dpa_mode != "OFF");

    typedef enum logic [3:0] {
        IDLE, DPA_WAIT, FIFO_RST, CDA_RST, SETTLE, CHECK, SLIP, NEXT, DONE
    } state_t;

    state_t          state, state_n;
    logic [CHW-1:0]  ch, ch_n;
    logic [15:0]     tmo_cnt, tmo_n;
    logic [7:0]      settle_cnt, settle_n;
    logic [3:0]      match_cnt, match_n;
    logic [SW-1:0]   slip_cnt, slip_n;
    logic            set_ok, set_fail;

    logic [NCH-1:0]  fifo_q, cda_q, slip_q, ok_q, fail_q;
    logic [NCH-1:0]  fifo_d, cda_d, slip_d, ok_d, fail_d;
    logic            busy_q, done_q, busy_d, done_d;

    logic [DF-1:0]   word;
    logic            locked;

    function automatic logic [NCH-1:0] onehot(input logic [CHW-1:0] idx);
        logic [NCH-1:0] r;
        r = '0;
        for (int unsigned c = 0; c < NCH; c++)
            if (idx == CHW'(c)) r[c] = 1'b1;
        return r;
    endfunction

    always_comb begin
        word   = '0;
        locked = 1'b0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (ch == CHW'(c)) begin
                word   = bus.rx_out[c*DF +: DF];
                locked = bus.rx_dpa_locked[c];
            end
        end
    end

    always_ff @(posedge rx_slowclk) begin
        if (rx_reset) begin
            state      <= IDLE;
            ch         <= '0;
            tmo_cnt    <= '0;
            settle_cnt <= '0;
            match_cnt  <= '0;
            slip_cnt   <= '0;
            fifo_q     <= '0;
            cda_q      <= '0;
            slip_q     <= '0;
            ok_q       <= '0;
            fail_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_n;
            ch         <= ch_n;
            tmo_cnt    <= tmo_n;
            settle_cnt <= settle_n;
            match_cnt  <= match_n;
            slip_cnt   <= slip_n;
            fifo_q     <= fifo_d;
            cda_q      <= cda_d;
            slip_q     <= slip_d;
            ok_q       <= ok_d;
            fail_q     <= fail_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_n  = state;
        ch_n     = ch;
        tmo_n    = tmo_cnt;
        settle_n = settle_cnt;
        match_n  = match_cnt;
        slip_n   = slip_cnt;
        set_ok   = 1'b0;
        set_fail = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    ch_n    = '0;
                    tmo_n   = '0;
                    state_n = DPA_ON ? DPA_WAIT : CDA_RST;
                end
            end
            DPA_WAIT: begin
                if (locked) begin
                    tmo_n   = '0;
                    state_n = FIFO_RST;
                end else if (tmo_cnt == 16'(dpa_timeout - 1)) begin
                    tmo_n    = '0;
                    set_fail = 1'b1;
                    state_n  = NEXT;
                end else begin
                    tmo_n = tmo_cnt + 16'd1;
                end
            end
            FIFO_RST: state_n = CDA_RST;
            CDA_RST: begin
                slip_n   = '0;
                settle_n = '0;
                state_n  = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt == 8'(settle_cycles - 1)) begin
                    settle_n = '0;
                    match_n  = '0;
                    state_n  = CHECK;
                end else begin
                    settle_n = settle_cnt + 8'd1;
                end
            end
            CHECK: begin
                if (word == training_pattern) begin
                    if (match_cnt == 4'(lock_match_count - 1)) begin
                        set_ok  = 1'b1;
                        state_n = NEXT;
                    end else begin
                        match_n = match_cnt + 4'd1;
                    end
                end else if (slip_cnt == SW'(data_align_rollover)) begin
                    set_fail = 1'b1;
                    state_n  = NEXT;
                end else begin
                    state_n = SLIP;
                end
            end
            SLIP: begin
                slip_n   = slip_cnt + SW'(1);
                settle_n = '0;
                state_n  = SETTLE;
            end
            NEXT: begin
                if (ch == CHW'(NCH - 1)) begin
                    state_n = DONE;
                end else begin
                    ch_n    = ch + CHW'(1);
                    tmo_n   = '0;
                    state_n = DPA_ON ? DPA_WAIT : CDA_RST;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Pulses are decoded from the next state so each one is registered and aligned with its state.
    always_comb begin
        fifo_d = (state_n == FIFO_RST) ? onehot(ch_n) : '0;
        cda_d  = (state_n == CDA_RST)  ? onehot(ch_n) : '0;
        slip_d = (state_n == SLIP)     ? onehot(ch_n) : '0;
        busy_d = busy_q;
        done_d = done_q;
        ok_d   = ok_q   | (set_ok   ? onehot(ch) : '0);
        fail_d = fail_q | (set_fail ? onehot(ch) : '0);
        if ((state == IDLE || state == DONE) && bus.start) begin
            busy_d = 1'b1;
            done_d = 1'b0;
            ok_d   = '0;
            fail_d = '0;
        end
        if (state == NEXT && state_n == DONE) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end
    end

    assign bus.rx_fifo_reset         = fifo_q;
    assign bus.rx_cda_reset          = cda_q;
    assign bus.rx_channel_data_align = slip_q;
    assign bus.align_ok              = ok_q;
    assign bus.align_fail            = fail_q;
    assign bus.busy                  = busy_q;
    assign bus.done                  = done_q;
endmodule

// File: tb/tb_lvds_rx_align_ctrl.sv
// Bench: expected per-cycle output trace built from the sequencing rules, plus a reactive receiver model.
module tb_lvds_rx_align_ctrl;
    localparam logic [7:0] PAT = 8'h6A;
    localparam int S = 4, L = 3, R = 8, T = 16;

    typedef struct packed {
        logic [3:0] fifo, cda, slp;
        logic       busy, done;
        logic [3:0] ok, fail;
    } obs_t;

    logic clk = 1'b0;
    logic rx_reset = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0;
    logic [3:0] locked = 4'hF;
    logic [31:0] rxw;
    int need[4] = '{0, 0, 0, 0};
    bit partial0 = 1'b0;

    int checks = 0, errors = 0;
    obs_t q0[$], q1[$];
    obs_t cur0 = '0, cur1 = '0, act0, act1;

    int pos[4] = '{0, 0, 0, 0};
    int kk[4]  = '{0, 0, 0, 0};
    int tot_f[4] = '{0, 0, 0, 0}, tot_c[4] = '{0, 0, 0, 0}, tot_s[4] = '{0, 0, 0, 0};
    int bf[4], bc[4], bs[4];
    logic [3:0] pf, pc, ps;

    always #5 clk = ~clk;

    lvds_rx_align_ctrl_if #(.number_of_channels(4), .deserialization_factor(8)) if0 ();
    lvds_rx_align_ctrl_if #(.number_of_channels(4), .deserialization_factor(8)) if1 ();

    lvds_rx_align_ctrl #(.number_of_channels(4), .deserialization_factor(8), .dpa_timeout(T))
        dut0 (.rx_slowclk(clk), .rx_reset(rx_reset), .bus(if0));
    lvds_rx_align_ctrl #(.number_of_channels(4), .deserialization_factor(8), .dpa_timeout(T),
                         .enable_dpa_mode("OFF"))
        dut1 (.rx_slowclk(clk), .rx_reset(rx_reset), .bus(if1));

    assign if0.start = start0;
    assign if1.start = start1;
    assign if0.rx_out = rxw;
    assign if1.rx_out = rxw;
    assign if0.rx_dpa_locked = locked;
    assign if1.rx_dpa_locked = locked;
    assign act0 = {if0.rx_fifo_reset, if0.rx_cda_reset, if0.rx_channel_data_align,
                   if0.busy, if0.done, if0.align_ok, if0.align_fail};
    assign act1 = {if1.rx_fifo_reset, if1.rx_cda_reset, if1.rx_channel_data_align,
                   if1.busy, if1.done, if1.align_ok, if1.align_fail};
    assign pf = if0.rx_fifo_reset | if1.rx_fifo_reset;
    assign pc = if0.rx_cda_reset | if1.rx_cda_reset;
    assign ps = if0.rx_channel_data_align | if1.rx_channel_data_align;

    // Receiver: each channel aligns at slip position need[c]; kk counts cycles since the last reset/slip.
    always @(posedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (pc[c] || ps[c]) kk[c] <= 1;
            else if (kk[c] < 1000) kk[c] <= kk[c] + 1;
            if (pc[c]) pos[c] <= 0;
            else if (ps[c]) pos[c] <= pos[c] + 1;
            tot_f[c] <= tot_f[c] + int'(pf[c]);
            tot_c[c] <= tot_c[c] + int'(pc[c]);
            tot_s[c] <= tot_s[c] + int'(ps[c]);
        end
    end

    always_comb begin
        rxw = '0;
        for (int c = 0; c < 4; c++)
            rxw[c*8 +: 8] = ((pos[c] == need[c]) ||
                             (partial0 && c == 0 && pos[c] == 0 && kk[c] <= S + 2)) ? PAT : ~PAT;
    end

    always @(negedge clk) begin
        if (q0.size() > 0) cur0 = q0.pop_front();
        if (q1.size() > 0) cur1 = q1.pop_front();
        checks += 2;
        if (act0 !== cur0) begin
            errors++;
            $display("FAIL trace_dut0 t=%0t got %h expected %h", $time, act0, cur0);
        end
        if (act1 !== cur1) begin
            errors++;
            $display("FAIL trace_dut1 t=%0t got %h expected %h", $time, act1, cur1);
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // One entry per cycle from the cycle after start through DONE.
    task automatic build(input int d, input bit dpa_on);
        obs_t e;
        obs_t t[$];
        e = '0;
        e.busy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (dpa_on) begin
                if (!locked[c]) begin
                    repeat (T) t.push_back(e);
                    e.fail[c] = 1'b1;
                    t.push_back(e);
                    continue;
                end
                t.push_back(e);
                e.fifo[c] = 1'b1; t.push_back(e); e.fifo = '0;
            end
            e.cda[c] = 1'b1; t.push_back(e); e.cda = '0;
            for (int s = 0; s <= R; s++) begin
                repeat (S) t.push_back(e);
                if (need[c] == s) begin
                    repeat (L) t.push_back(e);
                    e.ok[c] = 1'b1;
                    t.push_back(e);
                    break;
                end
                if (partial0 && c == 0 && s == 0) repeat (2) t.push_back(e);
                t.push_back(e);
                if (s == R) begin
                    e.fail[c] = 1'b1;
                    t.push_back(e);
                    break;
                end
                e.slp[c] = 1'b1; t.push_back(e); e.slp = '0;
            end
        end
        e.busy = 1'b0;
        e.done = 1'b1;
        t.push_back(e);
        if (d == 0) q0 = t; else q1 = t;
    endtask

    task automatic snap();
        for (int c = 0; c < 4; c++) begin
            bf[c] = tot_f[c]; bc[c] = tot_c[c]; bs[c] = tot_s[c];
        end
    endtask

    task automatic run(input int d, input bit dpa_on, input int exp_len);
        snap();
        @(posedge clk); #1;
        if (d == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        build(d, dpa_on);
        chk("trace_len", (d == 0) ? q0.size() : q1.size(), exp_len);
    endtask

    task automatic finish_run(input int d);
        int n = 0;
        while (((d == 0) ? q0.size() : q1.size()) != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL run_timeout got %0d cycles expected below 2000", n);
        end
        @(negedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs0", int'(act0), 0);
        chk("reset_outputs1", int'(act1), 0);
        rx_reset = 1'b0;

        // All locked, ch2 needs 3 slips.
        need = '{0, 0, 3, 0};
        run(0, 1'b1, 63);
        finish_run(0);
        chk("A_ok", int'(if0.align_ok), 15);
        chk("A_fail", int'(if0.align_fail), 0);
        chk("A_done", int'(if0.done), 1);
        chk("A_slips_ch2", tot_s[2] - bs[2], 3);
        chk("A_slips_other", (tot_s[0] - bs[0]) + (tot_s[1] - bs[1]) + (tot_s[3] - bs[3]), 0);

        // Ch1 never locks: DPA timeout.
        need = '{0, 0, 0, 0};
        locked = 4'b1101;
        run(0, 1'b1, 51);
        finish_run(0);
        chk("B_fail", int'(if0.align_fail), 2);
        chk("B_ok", int'(if0.align_ok), 13);
        chk("B_fifo_ch1", tot_f[1] - bf[1], 0);
        chk("B_cda_ch1", tot_c[1] - bc[1], 0);
        locked = 4'hF;

        // Ch0 never matches (fails after R slips); ch3 needs exactly R slips and passes.
        need = '{-1, 0, 0, R};
        run(0, 1'b1, 139);
        finish_run(0);
        chk("C_slips_ch0", tot_s[0] - bs[0], 8);
        chk("C_slips_ch3", tot_s[3] - bs[3], 8);
        chk("C_fail", int'(if0.align_fail), 1);
        chk("C_ok", int'(if0.align_ok), 14);

        // Reset during ch1 SETTLE, then a clean rerun.
        need = '{0, 0, 3, 0};
        run(0, 1'b1, 63);
        begin
            int n = 0;
            while (!if0.rx_cda_reset[1] && n < 500) begin
                @(negedge clk);
                n++;
            end
            chk("E_reach_ch1", int'(n < 500), 1);
        end
        @(posedge clk); #1;
        rx_reset = 1'b1;
        @(posedge clk); #1;
        q0.delete();
        cur0 = '0;
        chk("E_reset_outputs", int'(act0), 0);
        @(posedge clk); #1;
        rx_reset = 1'b0;
        run(0, 1'b1, 63);
        finish_run(0);
        chk("E_rerun_ok", int'(if0.align_ok), 15);
        chk("E_rerun_fail", int'(if0.align_fail), 0);

        // Second start while busy is ignored; ch0 matches 2 of 3 at slip 0, passes at slip 1.
        need = '{1, 0, 0, 0};
        partial0 = 1'b1;
        run(0, 1'b1, 53);
        repeat (3) @(posedge clk);
        #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        finish_run(0);
        chk("F_slips_ch0", tot_s[0] - bs[0], 1);
        chk("F_ok", int'(if0.align_ok), 15);
        partial0 = 1'b0;

        // DPA mode off, nothing locked.
        need = '{1, 0, 2, 0};
        locked = 4'h0;
        run(1, 1'b0, 55);
        finish_run(1);
        chk("D_fifo_total", (tot_f[0] - bf[0]) + (tot_f[1] - bf[1]) + (tot_f[2] - bf[2]) + (tot_f[3] - bf[3]), 0);
        chk("D_ok", int'(if1.align_ok), 15);
        chk("D_done", int'(if1.done), 1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
